seg_scan_driver: RTL

Segment-data stage of the 3-digit multiplexed 7-segment display. Accepts a binary measurement value (0–999) on a strobe, converts it to BCD with a sequential shift-add-3 engine, and commits the digits atomically so the scan never shows a half-updated value. Sits directly downstream of the rotating digit-select generator: it consumes that block's active-low one-hot select word and drives the matching segment pattern onto the shared segment bus.

---
 rtl/seg_pkg.sv | 56 +++++
 rtl/seg7_decode.sv | 32 +++
 rtl/seg_scan_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// +------------------------------------------------------------------+
// | seg_pkg: shared FSM states, segment patterns and digit indices    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CONV = ST_CONV,
    LOAD = ST_LOAD
  } state_e;

  // Active-low patterns, bit 7 = dp, bits 6:0 = g..a
  localparam logic [7:0] SEG_D0    = 8'hC0;
  localparam logic [7:0] SEG_D1    = 8'hF9;
  localparam logic [7:0] SEG_D2    = 8'hA4;
  localparam logic [7:0] SEG_D3    = 8'hB0;
  localparam logic [7:0] SEG_D4    = 8'h99;
  localparam logic [7:0] SEG_D5    = 8'h92;
  localparam logic [7:0] SEG_D6    = 8'h82;
  localparam logic [7:0] SEG_D7    = 8'hF8;
  localparam logic [7:0] SEG_D8    = 8'h80;
  localparam logic [7:0] SEG_D9    = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_NONE = 2'd3;

  function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_D0;
      4'd1:    return SEG_D1;
      4'd2:    return SEG_D2;
      4'd3:    return SEG_D3;
      4'd4:    return SEG_D4;
      4'd5:    return SEG_D5;
      4'd6:    return SEG_D6;
      4'd7:    return SEG_D7;
      4'd8:    return SEG_D8;
      4'd9:    return SEG_D9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// +------------------------------------------------------------------+
// | seg7_decode: one digit plus blank/dash/dp controls to segments    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    if (dash) begin
      pattern = SEG_DASH;
    end else if (blank) begin
      pattern = SEG_BLANK;
    end else begin
      pattern = seg_pattern(digit);
    end
    if (dp) begin
      pattern[7] = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// +------------------------------------------------------------------+
// | seg_scan_driver: binary to BCD, atomic commit, 3-digit seg drive  |
// | Option: SEG_LZB_EN enables leading-zero blanking.   Rev 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int VALUE_W  = 10,
  parameter int DP_DIGIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  input  logic [2:0]         sel,
  output logic [7:0]         seg,
  output logic               busy,
  output logic               overflow
);

  localparam int                CNT_W    = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(VALUE_W);

  state_e             r_state;
  logic [VALUE_W-1:0] r_bin;
  logic [11:0]        r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_conv_ovf;
  logic               r_pend_valid;
  logic [VALUE_W-1:0] r_pend_value;
  logic [3:0]         r_hund;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic               r_overflow;

  logic [11:0]        w_bcd_adj;
  logic               w_start;
  logic [VALUE_W-1:0] w_start_value;
  logic               w_sel_ok;
  logic [1:0]         w_idx;
  logic [3:0]         w_digit;
  logic               w_blank;
  logic               w_dp;
  logic [7:0]         w_pattern;

  function automatic logic over_range(input logic [VALUE_W-1:0] v);
    return 32'(v) > 32'd999;
  endfunction

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // A strobe arriving in LOAD is newer than the pending slot, so it wins
  assign w_start       = (value_valid && (r_state == IDLE || r_state == LOAD)) ||
                         (r_pend_valid && r_state == LOAD);
  assign w_start_value = value_valid ? value : r_pend_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_conv_ovf   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_value <= '0;
      r_hund       <= 4'd0;
      r_tens       <= 4'd0;
      r_ones       <= 4'd0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_start) begin
        r_state    <= CONV;
        r_bin      <= w_start_value;
        r_bcd      <= '0;
        r_cnt      <= CNT_INIT;
        r_conv_ovf <= over_range(w_start_value);
      end
      case (r_state)
        CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= LOAD;
          end
          if (value_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_value <= value;
          end
        end
        LOAD: begin
          r_hund       <= r_bcd[11:8];
          r_tens       <= r_bcd[7:4];
          r_ones       <= r_bcd[3:0];
          r_overflow   <= r_conv_ovf;
          r_pend_valid <= 1'b0;
          if (!w_start) begin
            r_state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;

  always_comb begin
    w_sel_ok = 1'b1;
    w_idx    = DIG_NONE;
    case (sel)
      3'b110:  w_idx    = DIG_ONES;
      3'b101:  w_idx    = DIG_TENS;
      3'b011:  w_idx    = DIG_HUND;
      default: w_sel_ok = 1'b0;
    endcase
    case (w_idx)
      DIG_ONES: w_digit = r_ones;
      DIG_TENS: w_digit = r_tens;
      default:  w_digit = r_hund;
    endcase
    w_dp = w_sel_ok && (w_idx == 2'(DP_DIGIT));
  end

`ifdef SEG_LZB_EN
  // DP_DIGIT = 3 means no decimal point, so no digit is protected from blanking
  localparam bit DP_LIT = (DP_DIGIT < 3);
  logic w_lead_zero;
  assign w_lead_zero = (w_idx == DIG_HUND && r_hund == 4'd0) ||
                       (w_idx == DIG_TENS && r_hund == 4'd0 && r_tens == 4'd0);
  assign w_blank     = w_lead_zero && !r_overflow &&
                       !(DP_LIT && (32'(w_idx) <= 32'(DP_DIGIT)));
`else
  assign w_blank = 1'b0;
`endif

  seg7_decode u_dec (
    .digit   (w_digit),
    .blank   (w_blank),
    .dash    (r_overflow),
    .dp      (w_dp),
    .pattern (w_pattern)
  );

  assign seg = w_sel_ok ? w_pattern : SEG_BLANK;

endmodule

`default_nettype wire
